// File: rtl/wb_master_initiator_pkg.sv
// Shared definitions for the Wishbone initiator: FSM encoding, bus widths
// common with the FPGA register responders, and the timed-out read pattern.
package wb_master_initiator_pkg;

    localparam int WB_ADDR_WIDTH = 7;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;

    localparam logic [31:0] TIMEOUT_RD_VALUE_DEF = 32'hDEF_FAB_AC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbm_state_e;

endpackage

// File: rtl/wb_master_initiator_if.sv
// Command, response and Wishbone bus bundle of the initiator; the master
// modport is the initiator's view, the slave modport the surrounding fabric.
interface wb_master_initiator_if #(
    parameter int ADDRWIDTH = 7,
    parameter int DATAWIDTH = 32
);
    logic                     Cmd_Valid_i;
    logic                     Cmd_Ready_o;
    logic                     Cmd_WE_i;
    logic [ADDRWIDTH-1:0]     Cmd_ADR_i;
    logic [DATAWIDTH-1:0]     Cmd_DAT_i;
    logic [DATAWIDTH/8-1:0]   Cmd_SEL_i;

    logic                     Rsp_Valid_o;
    logic                     Rsp_Ready_i;
    logic [DATAWIDTH-1:0]     Rsp_DAT_o;
    logic                     Rsp_Err_o;

    logic                     WBm_CYC_o;
    logic                     WBm_STB_o;
    logic                     WBm_WE_o;
    logic [ADDRWIDTH-1:0]     WBm_ADR_o;
    logic [DATAWIDTH/8-1:0]   WBm_SEL_o;
    logic [DATAWIDTH-1:0]     WBm_DAT_o;
    logic [DATAWIDTH-1:0]     WBm_DAT_i;
    logic                     WBm_ACK_i;

    modport master (
        input  Cmd_Valid_i, Cmd_WE_i, Cmd_ADR_i, Cmd_DAT_i, Cmd_SEL_i,
        output Cmd_Ready_o,
        output Rsp_Valid_o, Rsp_DAT_o, Rsp_Err_o,
        input  Rsp_Ready_i,
        output WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_ADR_o, WBm_SEL_o, WBm_DAT_o,
        input  WBm_DAT_i, WBm_ACK_i
    );

    modport slave (
        output Cmd_Valid_i, Cmd_WE_i, Cmd_ADR_i, Cmd_DAT_i, Cmd_SEL_i,
        input  Cmd_Ready_o,
        input  Rsp_Valid_o, Rsp_DAT_o, Rsp_Err_o,
        output Rsp_Ready_i,
        input  WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_ADR_o, WBm_SEL_o, WBm_DAT_o,
        output WBm_DAT_i, WBm_ACK_i
    );

endinterface

// File: rtl/wb_master_timeout_cntr.sv
// Loadable ACK-timeout down-counter with zero flag, plus a saturating
// counter of timeout events.
module wb_master_timeout_cntr #(
    parameter int CNTR_WIDTH    = 4,
    parameter int LOAD_VALUE    = 14,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     load_i,
    input  logic                     dec_i,
    input  logic                     evt_i,
    output logic                     zero_o,
    output logic [ERR_CNT_WIDTH-1:0] evt_cnt_o
);

    localparam logic [CNTR_WIDTH-1:0] LOAD_V = CNTR_WIDTH'(LOAD_VALUE);

    logic [CNTR_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ERR_CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD_V;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (evt_i && (evt_cnt_q != '1))
            evt_cnt_d = evt_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            evt_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign zero_o    = (cnt_q == '0);
    assign evt_cnt_o = evt_cnt_q;

endmodule

// File: rtl/wb_master_initiator.sv
// Single-outstanding Wishbone initiator: turns valid/ready commands into
// classic single read/write cycles, bounded by an ACK timeout.
module wb_master_initiator
    import wb_master_initiator_pkg::*;
#(
    parameter int                       ADDRWIDTH          = WB_ADDR_WIDTH,
    parameter int                       DATAWIDTH          = WB_DATA_WIDTH,
    parameter int                       TIMEOUT_CNTR_WIDTH = 4,
    parameter int                       TIMEOUT_CYCLES     = 15,
    parameter logic [DATAWIDTH-1:0]     TIMEOUT_RD_VALUE   = TIMEOUT_RD_VALUE_DEF,
    parameter int                       ERR_CNT_WIDTH      = 8
) (
    input  logic                     WBs_CLK_i,
    input  logic                     WBs_RST_n_i,
    wb_master_initiator_if.master    bus,
    output logic [ERR_CNT_WIDTH-1:0] Timeout_Cnt_o
);

    localparam int SELWIDTH = DATAWIDTH / 8;

    wbm_state_e state_q, state_d;

    logic                 cyc_q,       cyc_d;
    logic                 we_q,        we_d;
    logic [ADDRWIDTH-1:0] adr_q,       adr_d;
    logic [SELWIDTH-1:0]  sel_q,       sel_d;
    logic [DATAWIDTH-1:0] dat_q,       dat_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0] rsp_dat_q,   rsp_dat_d;
    logic                 rsp_err_q,   rsp_err_d;

    logic accept;
    logic bus_ack;
    logic bus_tmo;
    logic tmo_zero;

    assign accept  = (state_q == ST_IDLE) && bus.Cmd_Valid_i;
    assign bus_ack = (state_q == ST_BUS) && bus.WBm_ACK_i;
    // ACK wins over the timeout when both land on the same edge.
    assign bus_tmo = (state_q == ST_BUS) && !bus.WBm_ACK_i && tmo_zero;

    wb_master_timeout_cntr #(
        .CNTR_WIDTH    (TIMEOUT_CNTR_WIDTH),
        .LOAD_VALUE    (TIMEOUT_CYCLES - 1),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_tmo (
        .clk_i     (WBs_CLK_i),
        .rst_n_i   (WBs_RST_n_i),
        .load_i    (accept),
        .dec_i     ((state_q == ST_BUS) && !bus.WBm_ACK_i),
        .evt_i     (bus_tmo),
        .zero_o    (tmo_zero),
        .evt_cnt_o (Timeout_Cnt_o)
    );

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.Cmd_Valid_i)            state_d = ST_BUS;
            ST_BUS:  if (bus_ack || bus_tmo)         state_d = ST_RESP;
            ST_RESP: if (bus.Rsp_Ready_i)            state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Cmd_Valid_i) begin
                    cyc_d = 1'b1;
                    we_d  = bus.Cmd_WE_i;
                    adr_d = bus.Cmd_ADR_i;
                    sel_d = bus.Cmd_SEL_i;
                    if (bus.Cmd_WE_i)
                        dat_d = bus.Cmd_DAT_i;
                end
            end
            ST_BUS: begin
                if (bus_ack) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? '0 : bus.WBm_DAT_i;
                end else if (bus_tmo) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = we_q ? '0 : TIMEOUT_RD_VALUE;
                end
            end
            ST_RESP: begin
                if (bus.Rsp_Ready_i)
                    rsp_valid_d = 1'b0;
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.Cmd_Ready_o = (state_q == ST_IDLE);
    assign bus.WBm_CYC_o   = cyc_q;
    assign bus.WBm_STB_o   = cyc_q;
    assign bus.WBm_WE_o    = we_q;
    assign bus.WBm_ADR_o   = adr_q;
    assign bus.WBm_SEL_o   = sel_q;
    assign bus.WBm_DAT_o   = dat_q;
    assign bus.Rsp_Valid_o = rsp_valid_q;
    assign bus.Rsp_DAT_o   = rsp_dat_q;
    assign bus.Rsp_Err_o   = rsp_err_q;

endmodule

// File: doc/wb_master_initiator.md
Name: wb_master_initiator

Overview:
- Single-outstanding Wishbone initiator (master) for the FPGA fabric.
- Converts a valid/ready command interface into classic Wishbone single read/write cycles on the FPGA-side bus.
- Drives CYC/STB/WE/SEL/ADR/DAT; waits for ACK with a bounded timeout; returns read data and an error flag on a valid/ready response interface.
- Counterpart to the FPGA register/default-ack responders; lets fabric IP (e.g. a DMA or test engine) reach those registers without ever hanging.

Parameters:
ADDRWIDTH, 7, word address width of WBm_ADR_o and Cmd_ADR_i
DATAWIDTH, 32, data width
TIMEOUT_CNTR_WIDTH, 4, width of the ACK timeout counter
TIMEOUT_CYCLES, 15, consecutive no-ACK cycles before abort; legal range 1..2^TIMEOUT_CNTR_WIDTH
TIMEOUT_RD_VALUE, 32'hDEF_FAB_AC, Rsp_DAT_o value returned by a timed-out read
ERR_CNT_WIDTH, 8, width of the saturating timeout-event counter

Ports:
WBs_CLK_i  in  1  bus clock; all logic on its rising edge
WBs_RST_n_i  in  1  reset, asynchronous assert, active-low
Cmd_Valid_i  in  1  command request
Cmd_Ready_o  out  1  command accepted when high together with Cmd_Valid_i
Cmd_WE_i  in  1  1 = write, 0 = read
Cmd_ADR_i  in  ADDRWIDTH  word address
Cmd_DAT_i  in  DATAWIDTH  write data
Cmd_SEL_i  in  DATAWIDTH/8  byte enables
Rsp_Valid_o  out  1  response available
Rsp_Ready_i  in  1  response consumed
Rsp_DAT_o  out  DATAWIDTH  read data (0 for writes)
Rsp_Err_o  out  1  cycle ended by timeout
WBm_CYC_o, WBm_STB_o, WBm_WE_o  out  1 each  Wishbone controls
WBm_ADR_o  out  ADDRWIDTH  address
WBm_SEL_o  out  DATAWIDTH/8  byte enables
WBm_DAT_o  out  DATAWIDTH  write data
WBm_DAT_i  in  DATAWIDTH  read data
WBm_ACK_i  in  1  transfer acknowledge
Timeout_Cnt_o  out  ERR_CNT_WIDTH  saturating count of timed-out cycles

Behaviour:
- Reset (WBs_RST_n_i low, asynchronous):
  - State IDLE.
  - All outputs 0 except Cmd_Ready_o = 1.
  - Counters cleared.
  - Reset mid-cycle drops CYC/STB immediately; the pending response is discarded.
- States: IDLE, BUS, RESP. All Wishbone and response outputs are registered. Cmd_Ready_o = (state == IDLE).
- IDLE:
  - On Cmd_Valid_i at edge N: latch WE/ADR/DAT/SEL into the WBm_* registers.
  - Assert CYC = STB = 1 (visible after edge N).
  - Load timeout counter with TIMEOUT_CYCLES-1; go to BUS.
  - A write latches Cmd_DAT_i; WBm_DAT_o holds its last value otherwise.
- BUS: ADR/WE/SEL/DAT/CYC/STB held stable. At each edge, in priority order:
  1. WBm_ACK_i = 1:
     - Deassert CYC/STB.
     - Reads: Rsp_DAT_o <= WBm_DAT_i. Writes: Rsp_DAT_o <= 0.
     - Rsp_Err_o <= 0; Rsp_Valid_o <= 1; go to RESP.
  2. Counter == 0:
     - Deassert CYC/STB.
     - Rsp_DAT_o <= TIMEOUT_RD_VALUE for reads, 0 for writes.
     - Rsp_Err_o <= 1; Rsp_Valid_o <= 1.
     - Timeout_Cnt_o increments, saturating at all-ones; go to RESP.
  3. Otherwise decrement the counter.
- Latency: ACK sampled at edge N+k gives CYC low and Rsp_Valid_o high after edge N+k. Without ACK, timeout fires at edge N+TIMEOUT_CYCLES.
- Simultaneous events: ACK coinciding with the timeout edge counts as success.
- RESP:
  - Rsp_Valid_o, Rsp_DAT_o and Rsp_Err_o held until Rsp_Ready_i = 1.
  - On that edge Rsp_Valid_o <= 0 and state goes to IDLE; the next command can be accepted no earlier than the following edge.
- WBm_ACK_i outside BUS (a late ACK after timeout, or a stray ACK) is ignored. It changes no state or counter.
- CYC and STB are always equal; no pipelined, burst or retry cycles.

Decomposition:
- Shared package:
  - State encodings (IDLE/BUS/RESP).
  - TIMEOUT_RD_VALUE default.
  - Wishbone address/data width constants shared with the FPGA register responders.
- One natural sub-module: wb_master_timeout_cntr.
  - Loadable down-counter with zero flag, plus the saturating event counter.
- The FSM stays in wb_master_initiator.

Test Plan:
- Read, responder ACKs at 2nd BUS cycle, WBm_DAT_i = 32'h0001_0000 -> CYC high exactly 2 cycles, Rsp_DAT_o = 32'h0001_0000, Rsp_Err_o = 0, Timeout_Cnt_o = 0.
- Write ADR = 7'h7E, DAT = 32'hA5A5_5A5A, SEL = 4'hF, ACK after 1 cycle -> WBm_* match the command and stay stable while CYC is high; Rsp_DAT_o = 0, Rsp_Err_o = 0.
- Read, no ACK -> CYC high for 15 cycles, then Rsp_Err_o = 1, Rsp_DAT_o = 32'hDEF_FAB_AC, Timeout_Cnt_o = 1; ACK injected 2 cycles later -> ignored, state stays RESP/IDLE.
- ACK arrives on the exact timeout edge (cycle 15) -> success response, Rsp_Err_o = 0, Timeout_Cnt_o unchanged.
- Rsp_Ready_i held low 5 cycles with Cmd_Valid_i high -> Cmd_Ready_o = 0 and no new CYC; after Rsp_Ready_i pulse -> next command accepted one cycle later.
- WBs_RST_n_i asserted mid-BUS -> CYC/STB/Rsp_Valid_o low without a clock edge; after release Cmd_Ready_o = 1; 300 forced timeouts -> Timeout_Cnt_o saturates at 8'hFF.
